// File: rtl/reg_access_arbiter.sv
// -----------------------------------------------------------------------------
// reg_access_arbiter
//
// Shares one bank of REG_NUM register modules between two requesters
// (A = host config port, B = debug/test port). One transaction is in flight at
// a time. Each access walks IDLE -> ACC -> WAIT -> RESP -> IDLE:
//   IDLE : round-robin pick, payload and decoded address latched on acceptance
//   ACC  : single-cycle one-hot select strobe to the addressed register
//   WAIT : select dropped, addressed read slice captured at the end of cycle
//   RESP : one-cycle response pulse to the winner only
//
// Ports
//   clk, rst_n                        clock, asynchronous active-low reset
//   a_req_valid/wr/addr/wdata         requester A request (held until ready)
//   a_req_ready                       A accepted this cycle (combinational)
//   a_rsp_valid/rdata/err             A one-cycle response
//   b_*                               same set for requester B
//   reg_wr_sel                        one-hot register select (bit i -> reg i)
//   reg_wr_rd                         1 = write, 0 = read (shared)
//   reg_wr_data                       write data (shared)
//   reg_rd_bus                        concatenated register read outputs
// -----------------------------------------------------------------------------
module reg_access_arbiter #(
  parameter int REG_WIDTH  = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int REG_NUM    = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         a_req_valid,
  input  logic                         a_req_wr,
  input  logic [ADDR_WIDTH-1:0]        a_req_addr,
  input  logic [REG_WIDTH-1:0]         a_req_wdata,
  output logic                         a_req_ready,
  output logic                         a_rsp_valid,
  output logic [REG_WIDTH-1:0]         a_rsp_rdata,
  output logic                         a_rsp_err,
  input  logic                         b_req_valid,
  input  logic                         b_req_wr,
  input  logic [ADDR_WIDTH-1:0]        b_req_addr,
  input  logic [REG_WIDTH-1:0]         b_req_wdata,
  output logic                         b_req_ready,
  output logic                         b_rsp_valid,
  output logic [REG_WIDTH-1:0]         b_rsp_rdata,
  output logic                         b_rsp_err,
  output logic [REG_NUM-1:0]           reg_wr_sel,
  output logic                         reg_wr_rd,
  output logic [REG_WIDTH-1:0]         reg_wr_data,
  input  logic [REG_NUM*REG_WIDTH-1:0] reg_rd_bus
);

  localparam int IDX_W = ADDR_WIDTH - 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } state_e;

  // One-hot register select; all-zero for an erroneous address so that
  // no register ever sees a strobe for it.
  function automatic logic [REG_NUM-1:0] onehot_sel(input logic [IDX_W-1:0] idx,
                                                    input logic             err);
    logic [REG_NUM-1:0] sel;
    sel = '0;
    for (int i = 0; i < REG_NUM; i++) begin
      sel[i] = (32'(idx) == 32'(i)) & ~err;
    end
    return sel;
  endfunction

  state_e                 state_q, state_d;
  logic                   last_grant_q, last_grant_d;   // 0 = A, 1 = B
  logic                   winner_q, winner_d;           // 0 = A, 1 = B
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic                   err_q, err_d;
  logic [REG_NUM-1:0]     sel_q, sel_d;
  logic                   wr_q, wr_d;
  logic [REG_WIDTH-1:0]   wdata_q, wdata_d;
  logic                   a_rsp_valid_q, a_rsp_valid_d;
  logic [REG_WIDTH-1:0]   a_rsp_rdata_q, a_rsp_rdata_d;
  logic                   a_rsp_err_q, a_rsp_err_d;
  logic                   b_rsp_valid_q, b_rsp_valid_d;
  logic [REG_WIDTH-1:0]   b_rsp_rdata_q, b_rsp_rdata_d;
  logic                   b_rsp_err_q, b_rsp_err_d;

  logic                   win_a_s, win_b_s;
  logic                   req_wr_s;
  logic [ADDR_WIDTH-1:0]  req_addr_s;
  logic [REG_WIDTH-1:0]   req_wdata_s;
  logic [IDX_W-1:0]       req_idx_s;
  logic                   req_err_s;
  logic [REG_WIDTH-1:0]   rd_slice_s;

  // Round-robin pick, winner payload mux and address decode.
  always_comb begin
    // A sole requester always wins; on contention the one not granted last wins.
    win_a_s     = a_req_valid & (~b_req_valid | last_grant_q);
    win_b_s     = b_req_valid & (~a_req_valid | ~last_grant_q);
    req_wr_s    = 1'b0;
    req_addr_s  = '0;
    req_wdata_s = '0;
    if (win_b_s) begin
      req_wr_s    = b_req_wr;
      req_addr_s  = b_req_addr;
      req_wdata_s = b_req_wdata;
    end else begin
      req_wr_s    = a_req_wr;
      req_addr_s  = a_req_addr;
      req_wdata_s = a_req_wdata;
    end
    req_idx_s = req_addr_s[ADDR_WIDTH-1:2];
    req_err_s = (req_addr_s[1:0] != 2'b00) | (32'(req_idx_s) >= 32'(REG_NUM));
  end

  // Read slice of the latched index; OR-mux so an out-of-range index gives 0.
  always_comb begin
    rd_slice_s = '0;
    for (int i = 0; i < REG_NUM; i++) begin
      rd_slice_s = rd_slice_s |
                   (reg_rd_bus[i*REG_WIDTH +: REG_WIDTH] &
                    {REG_WIDTH{32'(idx_q) == 32'(i)}});
    end
  end

  // Next-state and registered-output logic of the access sequencer.
  always_comb begin
    state_d       = state_q;
    last_grant_d  = last_grant_q;
    winner_d      = winner_q;
    idx_d         = idx_q;
    err_d         = err_q;
    wr_d          = wr_q;
    wdata_d       = wdata_q;
    sel_d         = '0;
    a_rsp_valid_d = 1'b0;
    a_rsp_rdata_d = '0;
    a_rsp_err_d   = 1'b0;
    b_rsp_valid_d = 1'b0;
    b_rsp_rdata_d = '0;
    b_rsp_err_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (win_a_s | win_b_s) begin
          state_d      = ST_ACC;
          winner_d     = win_b_s;
          last_grant_d = win_b_s;
          idx_d        = req_idx_s;
          err_d        = req_err_s;
          wr_d         = req_wr_s;
          wdata_d      = req_wdata_s;
          sel_d        = onehot_sel(req_idx_s, req_err_s);
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ACC: begin
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        state_d = ST_RESP;
        // Response is registered here so it shows during RESP.
        if (winner_q) begin
          b_rsp_valid_d = 1'b1;
          b_rsp_err_d   = err_q;
          b_rsp_rdata_d = (~wr_q & ~err_q) ? rd_slice_s : '0;
        end else begin
          a_rsp_valid_d = 1'b1;
          a_rsp_err_d   = err_q;
          a_rsp_rdata_d = (~wr_q & ~err_q) ? rd_slice_s : '0;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset drops any in-flight access.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      last_grant_q  <= 1'b1;
      winner_q      <= 1'b0;
      idx_q         <= '0;
      err_q         <= 1'b0;
      wr_q          <= 1'b0;
      wdata_q       <= '0;
      sel_q         <= '0;
      a_rsp_valid_q <= 1'b0;
      a_rsp_rdata_q <= '0;
      a_rsp_err_q   <= 1'b0;
      b_rsp_valid_q <= 1'b0;
      b_rsp_rdata_q <= '0;
      b_rsp_err_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      last_grant_q  <= last_grant_d;
      winner_q      <= winner_d;
      idx_q         <= idx_d;
      err_q         <= err_d;
      wr_q          <= wr_d;
      wdata_q       <= wdata_d;
      sel_q         <= sel_d;
      a_rsp_valid_q <= a_rsp_valid_d;
      a_rsp_rdata_q <= a_rsp_rdata_d;
      a_rsp_err_q   <= a_rsp_err_d;
      b_rsp_valid_q <= b_rsp_valid_d;
      b_rsp_rdata_q <= b_rsp_rdata_d;
      b_rsp_err_q   <= b_rsp_err_d;
    end
  end

  assign a_req_ready = (state_q == ST_IDLE) & win_a_s;
  assign b_req_ready = (state_q == ST_IDLE) & win_b_s;
  assign a_rsp_valid = a_rsp_valid_q;
  assign a_rsp_rdata = a_rsp_rdata_q;
  assign a_rsp_err   = a_rsp_err_q;
  assign b_rsp_valid = b_rsp_valid_q;
  assign b_rsp_rdata = b_rsp_rdata_q;
  assign b_rsp_err   = b_rsp_err_q;
  // wr/wdata stay on the shared bus from ACC until the next acceptance.
  assign reg_wr_sel  = sel_q;
  assign reg_wr_rd   = wr_q;
  assign reg_wr_data = wdata_q;

endmodule

// File: tb/tb_reg_access_arbiter.sv
// -----------------------------------------------------------------------------
// Testbench for reg_access_arbiter: directed requests, scoreboard queues per
// requester filled at issue time, a negedge monitor that checks strobes,
// responses, latency and grant order.
// -----------------------------------------------------------------------------
module tb_reg_access_arbiter;

  logic         clk;
  logic         rst_n;
  logic         a_req_valid, a_req_wr, a_req_ready, a_rsp_valid, a_rsp_err;
  logic [7:0]   a_req_addr;
  logic [31:0]  a_req_wdata, a_rsp_rdata;
  logic         b_req_valid, b_req_wr, b_req_ready, b_rsp_valid, b_rsp_err;
  logic [7:0]   b_req_addr;
  logic [31:0]  b_req_wdata, b_rsp_rdata;
  logic [7:0]   reg_wr_sel;
  logic         reg_wr_rd;
  logic [31:0]  reg_wr_data;
  logic [255:0] reg_rd_bus;

  reg_access_arbiter #(.REG_WIDTH(32), .ADDR_WIDTH(8), .REG_NUM(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_req_valid(a_req_valid), .a_req_wr(a_req_wr), .a_req_addr(a_req_addr),
    .a_req_wdata(a_req_wdata), .a_req_ready(a_req_ready), .a_rsp_valid(a_rsp_valid),
    .a_rsp_rdata(a_rsp_rdata), .a_rsp_err(a_rsp_err),
    .b_req_valid(b_req_valid), .b_req_wr(b_req_wr), .b_req_addr(b_req_addr),
    .b_req_wdata(b_req_wdata), .b_req_ready(b_req_ready), .b_rsp_valid(b_rsp_valid),
    .b_rsp_rdata(b_rsp_rdata), .b_rsp_err(b_rsp_err),
    .reg_wr_sel(reg_wr_sel), .reg_wr_rd(reg_wr_rd), .reg_wr_data(reg_wr_data),
    .reg_rd_bus(reg_rd_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    logic [7:0]  sel;
    logic        wr;
    logic [31:0] wdata;
  } exp_t;

  exp_t exp_a_q[$];
  exp_t exp_b_q[$];
  int   acc_a_q[$];
  int   acc_b_q[$];
  byte  grant_who_q[$];
  int   grant_cyc_q[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   pend_cyc = -100;
  logic [7:0]  pend_sel = 8'h00;
  logic        pend_wr = 1'b0;
  logic [31:0] pend_wdata = 32'h0;

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
    tests++;
    if (act !== exp_v) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp_v, cyc);
    end
  endfunction

  // Monitor: strobe timing, grant log and scoreboard compare on responses.
  always @(negedge clk) begin
    exp_t e;
    int   acc;
    cyc++;
    if (!rst_n) begin
      chk("reset_outputs",
          {32'h0, a_req_ready, a_rsp_valid, a_rsp_err, b_req_ready, b_rsp_valid,
           b_rsp_err, reg_wr_rd, (|reg_wr_sel), (|a_rsp_rdata), (|b_rsp_rdata), (|reg_wr_data)},
          64'h0);
      acc_a_q.delete();
      acc_b_q.delete();
      pend_cyc = -100;
    end else begin
      if (cyc == pend_cyc + 1) begin
        chk("acc_sel", {56'h0, reg_wr_sel}, {56'h0, pend_sel});
        chk("acc_wr_rd", {63'h0, reg_wr_rd}, {63'h0, pend_wr});
        if (pend_wr) chk("acc_wdata", {32'h0, reg_wr_data}, {32'h0, pend_wdata});
      end
      if (cyc == pend_cyc + 2) chk("wait_sel_clear", {56'h0, reg_wr_sel}, 64'h0);
      if (a_req_ready || b_req_ready) begin
        chk("single_ready", {63'h0, a_req_ready & b_req_ready}, 64'h0);
        if (a_req_ready && exp_a_q.size() > 0) begin
          pend_sel = exp_a_q[0].sel; pend_wr = exp_a_q[0].wr; pend_wdata = exp_a_q[0].wdata;
        end
        if (b_req_ready && exp_b_q.size() > 0) begin
          pend_sel = exp_b_q[0].sel; pend_wr = exp_b_q[0].wr; pend_wdata = exp_b_q[0].wdata;
        end
        pend_cyc = cyc;
        if (a_req_ready) begin acc_a_q.push_back(cyc); grant_who_q.push_back(8'h41); end
        if (b_req_ready) begin acc_b_q.push_back(cyc); grant_who_q.push_back(8'h42); end
        grant_cyc_q.push_back(cyc);
      end
      if (a_rsp_valid) begin
        if (exp_a_q.size() == 0) begin
          chk("a_rsp_unexpected", 64'h1, 64'h0);
        end else begin
          e = exp_a_q.pop_front();
          acc = (acc_a_q.size() > 0) ? acc_a_q.pop_front() : -100;
          chk("a_rsp_rdata", {32'h0, a_rsp_rdata}, {32'h0, e.rdata});
          chk("a_rsp_err", {63'h0, a_rsp_err}, {63'h0, e.err});
          chk("a_rsp_latency", 64'(cyc - acc), 64'd3);
          chk("a_rsp_other_quiet", {31'h0, b_rsp_valid, b_rsp_rdata}, 64'h0);
        end
      end
      if (b_rsp_valid) begin
        if (exp_b_q.size() == 0) begin
          chk("b_rsp_unexpected", 64'h1, 64'h0);
        end else begin
          e = exp_b_q.pop_front();
          acc = (acc_b_q.size() > 0) ? acc_b_q.pop_front() : -100;
          chk("b_rsp_rdata", {32'h0, b_rsp_rdata}, {32'h0, e.rdata});
          chk("b_rsp_err", {63'h0, b_rsp_err}, {63'h0, e.err});
          chk("b_rsp_latency", 64'(cyc - acc), 64'd3);
          chk("b_rsp_other_quiet", {31'h0, a_rsp_valid, a_rsp_rdata}, 64'h0);
        end
      end
    end
  end

  // Issue one request on port (0 = A, 1 = B), hold until accepted, then drop valid.
  task automatic req(input bit port, input bit wr, input logic [7:0] addr,
                     input logic [31:0] wdata, input logic [31:0] exp_rdata,
                     input bit exp_err, input logic [7:0] exp_sel);
    exp_t e;
    int   n;
    bit   rdy;
    e.rdata = exp_rdata; e.err = exp_err; e.sel = exp_sel; e.wr = wr; e.wdata = wdata;
    if (port == 1'b0) begin
      exp_a_q.push_back(e);
      a_req_valid = 1'b1; a_req_wr = wr; a_req_addr = addr; a_req_wdata = wdata;
    end else begin
      exp_b_q.push_back(e);
      b_req_valid = 1'b1; b_req_wr = wr; b_req_addr = addr; b_req_wdata = wdata;
    end
    n = 0;
    rdy = 1'b0;
    while (!rdy && n < 60) begin
      @(negedge clk);
      n++;
      rdy = (port == 1'b0) ? a_req_ready : b_req_ready;
    end
    if (!rdy) chk("accept_timeout", 64'h0, 64'h1);
    @(posedge clk);
    #1;
    if (port == 1'b0) a_req_valid = 1'b0;
    else b_req_valid = 1'b0;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_slice(input int i, input logic [31:0] v);
    reg_rd_bus[i*32 +: 32] = v;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    wait_cycles(2);
    rst_n = 1'b1;
    wait_cycles(1);
  endtask

  task automatic clear_grants();
    grant_who_q.delete();
    grant_cyc_q.delete();
  endtask

  // Check the grant log: 'A'/'B' sequence given as a string, spacing of 4 cycles.
  task automatic check_grants(input string nm, input string order);
    chk({nm, "_count"}, 64'(grant_who_q.size()), 64'(order.len()));
    for (int i = 0; i < order.len(); i++) begin
      if (i < grant_who_q.size()) begin
        chk({nm, "_who"}, {56'h0, grant_who_q[i]}, {56'h0, order[i]});
        if (i > 0) chk({nm, "_spacing"}, 64'(grant_cyc_q[i] - grant_cyc_q[i-1]), 64'd4);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b1;
    a_req_valid = 1'b0; a_req_wr = 1'b0; a_req_addr = 8'h00; a_req_wdata = 32'h0;
    b_req_valid = 1'b0; b_req_wr = 1'b0; b_req_addr = 8'h00; b_req_wdata = 32'h0;
    reg_rd_bus = 256'h0;
    #1 rst_n = 1'b0;
    wait_cycles(3);
    rst_n = 1'b1;
    wait_cycles(1);

    // Write then read, requester A alone.
    req(1'b0, 1'b1, 8'h04, 32'h0000_0001, 32'h0000_0000, 1'b0, 8'b0000_0010);
    wait_cycles(4);
    set_slice(1, 32'h0000_0001);
    req(1'b0, 1'b0, 8'h04, 32'h0, 32'h0000_0001, 1'b0, 8'b0000_0010);
    wait_cycles(4);

    // Contention right after reset: A, then B (A re-requests at once), then A.
    for (int i = 0; i < 8; i++) set_slice(i, 32'hA5A5_0000 + 32'(i));
    do_reset();
    clear_grants();
    fork
      begin
        req(1'b0, 1'b0, 8'h00, 32'h0, 32'hA5A5_0000, 1'b0, 8'b0000_0001);
        req(1'b0, 1'b0, 8'h08, 32'h0, 32'hA5A5_0002, 1'b0, 8'b0000_0100);
      end
      req(1'b1, 1'b0, 8'h0C, 32'h0, 32'hA5A5_0003, 1'b0, 8'b0000_1000);
    join
    wait_cycles(4);
    check_grants("contention", "ABA");

    // Bad addresses: misaligned (A) and out-of-range index (B).
    req(1'b0, 1'b0, 8'h02, 32'h0, 32'h0, 1'b1, 8'h00);
    wait_cycles(4);
    req(1'b1, 1'b0, 8'h20, 32'h0, 32'h0, 1'b1, 8'h00);
    wait_cycles(4);
    // Write to a bad address must not strobe anything either.
    req(1'b1, 1'b1, 8'h23, 32'h1234_5678, 32'h0, 1'b1, 8'h00);
    wait_cycles(4);

    // Back-to-back streams, last grant is B so A goes first.
    clear_grants();
    fork
      begin
        req(1'b0, 1'b0, 8'h00, 32'h0, 32'hA5A5_0000, 1'b0, 8'b0000_0001);
        req(1'b0, 1'b0, 8'h04, 32'h0, 32'hA5A5_0001, 1'b0, 8'b0000_0010);
        req(1'b0, 1'b0, 8'h08, 32'h0, 32'hA5A5_0002, 1'b0, 8'b0000_0100);
        req(1'b0, 1'b0, 8'h0C, 32'h0, 32'hA5A5_0003, 1'b0, 8'b0000_1000);
      end
      begin
        req(1'b1, 1'b0, 8'h10, 32'h0, 32'hA5A5_0004, 1'b0, 8'b0001_0000);
        req(1'b1, 1'b0, 8'h14, 32'h0, 32'hA5A5_0005, 1'b0, 8'b0010_0000);
        req(1'b1, 1'b0, 8'h18, 32'h0, 32'hA5A5_0006, 1'b0, 8'b0100_0000);
        req(1'b1, 1'b0, 8'h1C, 32'h0, 32'hA5A5_0007, 1'b0, 8'b1000_0000);
      end
    join
    wait_cycles(4);
    check_grants("stream", "ABABABAB");

    // Reset during WAIT of a B read: transaction dropped, outputs clear at once.
    req(1'b1, 1'b0, 8'h08, 32'h0, 32'hA5A5_0002, 1'b0, 8'b0000_0100);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset_clear",
        {31'h0, reg_wr_rd, (|reg_wr_sel), b_rsp_valid, b_rsp_err, (|b_rsp_rdata),
         a_rsp_valid, (|reg_wr_data), 25'h0}, 64'h0);
    wait_cycles(2);
    exp_b_q.delete();
    rst_n = 1'b1;
    wait_cycles(4);

    // Read-data isolation with contention after reset: A wins first.
    for (int i = 0; i < 7; i++) set_slice(i, 32'hFFFF_FFFF);
    set_slice(7, 32'hDEAD_BEEF);
    clear_grants();
    fork
      req(1'b0, 1'b0, 8'h1C, 32'h0, 32'hDEAD_BEEF, 1'b0, 8'b1000_0000);
      req(1'b1, 1'b0, 8'h00, 32'h0, 32'hFFFF_FFFF, 1'b0, 8'b0000_0001);
    join
    wait_cycles(6);
    check_grants("post_reset", "AB");

    chk("a_queue_drained", 64'(exp_a_q.size()), 64'd0);
    chk("b_queue_drained", 64'(exp_b_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
